// File: rtl/fsmd_pkg.sv
// Shared definitions for the FSMD operand loader.
// Contents: loader state type, operand count, default operand width, slot index width.
// Config macro: FSMD_LOADER_CHECKSUM_EN adds the StChk state to the state type.
package fsmd_pkg;

  localparam int unsigned N_OPERANDS     = 5;
  localparam int unsigned DEFAULT_DATA_W = 4;
  localparam int unsigned IDX_W          = $clog2(N_OPERANDS);

`ifdef FSMD_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StChk   = 2'd1,
    StIssue = 2'd2,
    StWait  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StLoad  = 2'd0,
    StIssue = 2'd2,
    StWait  = 2'd3
  } state_e;
`endif

endpackage

// File: rtl/fsmd_done_timer.sv
// Done/timeout counter for the operand loader.
// Counts enabled cycles from 0 and flags the cycle on which the count equals DONE_TIMEOUT-1.
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-high reset
//   clear   - synchronous clear of the count
//   enable  - count this cycle
//   expired - enable is high and the count has reached DONE_TIMEOUT-1
module fsmd_done_timer #(
  parameter int unsigned DONE_TIMEOUT = 100
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CntW = $clog2(DONE_TIMEOUT);
  localparam logic [CntW-1:0] LastCnt = CntW'(DONE_TIMEOUT - 1);

  logic [CntW-1:0] count_q;

  assign expired = enable && (count_q == LastCnt);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/fsmd_operand_loader.sv
// Serial operand loader feeding a downstream FSMD.
// Collects five beats into shadow slots, presents them on a..e with a one-cycle start pulse,
// then waits for done (or a timeout, which pulses err) before accepting the next set.
// Config macro: FSMD_LOADER_CHECKSUM_EN adds a sixth checksum beat (XOR of the five operands);
// a mismatch pulses err and discards the set.
// Ports:
//   clock, reset       - clock and synchronous active-high reset
//   in_data, in_valid  - serial operand beat and its valid
//   in_ready           - beat accepted when in_valid && in_ready
//   a, b, c, d, e      - operand set for the downstream FSMD
//   start              - one-cycle pulse: operand set valid
//   done               - downstream FSMD finished with the current set
//   busy               - operand set in flight
//   err                - one-cycle error pulse (timeout or checksum mismatch)
module fsmd_operand_loader
  import fsmd_pkg::*;
#(
  parameter int unsigned DATA_W       = DEFAULT_DATA_W,
  parameter int unsigned DONE_TIMEOUT = 100
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] e,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              err
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_OPERANDS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shadow_q [N_OPERANDS];
  logic [DATA_W-1:0] merged   [N_OPERANDS];
  logic [DATA_W-1:0] ops_q    [N_OPERANDS];
  logic              shadow_wr;
  logic              load_ops;
  logic              err_d;
  logic              in_wait;
  logic              expired;

`ifdef FSMD_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  always_comb begin
    csum = '0;
    for (int i = 0; i < N_OPERANDS; i++) begin
      csum = csum ^ shadow_q[i];
    end
  end
`endif

  // Shadow slots with the beat accepted this cycle already merged in, so the
  // final beat can be forwarded straight to a..e on the edge that enters ISSUE.
  always_comb begin
    for (int i = 0; i < N_OPERANDS; i++) begin
      merged[i] = shadow_q[i];
      if (shadow_wr && (idx_q == IDX_W'(i))) begin
        merged[i] = in_data;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    in_ready  = 1'b0;
    start     = 1'b0;
    busy      = 1'b0;
    shadow_wr = 1'b0;
    load_ops  = 1'b0;
    err_d     = 1'b0;
    unique case (state_q)
      StLoad: begin
        in_ready = !reset;
        if (in_valid && in_ready) begin
          shadow_wr = 1'b1;
          if (idx_q == LastIdx) begin
            idx_d = '0;
`ifdef FSMD_LOADER_CHECKSUM_EN
            state_d = StChk;
`else
            state_d  = StIssue;
            load_ops = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef FSMD_LOADER_CHECKSUM_EN
      StChk: begin
        in_ready = !reset;
        if (in_valid && in_ready) begin
          if (in_data == csum) begin
            state_d  = StIssue;
            load_ops = 1'b1;
          end else begin
            state_d = StLoad;
            err_d   = 1'b1;
          end
        end
      end
`endif
      StIssue: begin
        start   = 1'b1;
        busy    = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        busy = 1'b1;
        // done has priority over a coincident timeout
        if (done) begin
          state_d = StLoad;
        end else if (expired) begin
          state_d = StLoad;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = StLoad;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx_q <= '0;
      err   <= 1'b0;
      for (int i = 0; i < N_OPERANDS; i++) begin
        shadow_q[i] <= '0;
        ops_q[i]    <= '0;
      end
    end else begin
      idx_q <= idx_d;
      err   <= err_d;
      for (int i = 0; i < N_OPERANDS; i++) begin
        shadow_q[i] <= merged[i];
        if (load_ops) begin
          ops_q[i] <= merged[i];
        end
      end
    end
  end

  assign in_wait = (state_q == StWait);

  fsmd_done_timer #(
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) u_done_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (!in_wait),
    .enable (in_wait),
    .expired(expired)
  );

  assign a = ops_q[0];
  assign b = ops_q[1];
  assign c = ops_q[2];
  assign d = ops_q[3];
  assign e = ops_q[4];

endmodule

// File: doc/fsmd_operand_loader.md
FSMD_OPERAND_LOADER -- requirements
Module: fsmd_operand_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 4, giving the operand width in bits.
REQ-002 The block SHALL have parameter DONE_TIMEOUT, default 100, giving the maximum cycles to wait for done after start (minimum 2).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_data, input, DATA_W bits: serial operand beat.
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a beat when in_valid and in_ready are both high.
REQ-008 The block SHALL have ports a, b, c, d and e, each output, DATA_W bits: the operand set presented to the downstream FSMD.
REQ-009 The block SHALL have port start, output, 1 bit: one-cycle pulse meaning the operand set is valid.
REQ-010 The block SHALL have port done, input, 1 bit: the downstream FSMD has finished with the current set.
REQ-011 The block SHALL have port busy, output, 1 bit: an operand set is in flight.
REQ-012 The block SHALL have port err, output, 1 bit: one-cycle error pulse.

Function
REQ-013 The FSM SHALL have states LOAD, CHK (only when the macro is defined), ISSUE and WAIT.
REQ-014 In LOAD and CHK, in_ready SHALL be 1; in ISSUE and WAIT, and in any cycle where reset is high, in_ready SHALL be 0.
REQ-015 In LOAD, each accepted beat SHALL be written to shadow slot idx (0..4 maps to a..e), and idx SHALL increment.
REQ-016 Outputs a..e SHALL NOT change while in LOAD, CHK or WAIT; they SHALL update only on the edge that enters ISSUE, from the shadow slots with the final beat merged in.
REQ-017 Without the macro, the edge that accepts the 5th beat SHALL enter ISSUE; start SHALL then be high for exactly the following cycle.
REQ-018 ISSUE SHALL last exactly one cycle, with start=1 and busy=1, and SHALL then move to WAIT.
REQ-019 In WAIT, busy SHALL be 1, and a timer SHALL count from 0 starting on the first WAIT cycle.
REQ-020 In WAIT, done=1 SHALL cause a move to LOAD with idx=0 and the timer cleared; err SHALL stay 0.
REQ-021 If the timer reaches DONE_TIMEOUT-1 with done=0, the block SHALL pulse err for one cycle and move to LOAD with idx=0.
REQ-022 If done=1 and the timeout occur in the same cycle, done SHALL win and there SHALL be no err pulse.
REQ-023 done SHALL be ignored in LOAD, CHK and ISSUE.
REQ-024 in_valid with in_ready=0 SHALL have no effect on any state.
REQ-025 Back-to-back sets SHALL be supported: the first beat of the next set can be accepted in the first LOAD cycle after done.

Reset
REQ-026 On any clock edge with reset=1, the following SHALL be set: state=LOAD, idx=0, timer=0, shadow slots=0, a..e=0, start=0, busy=0, err=0.
REQ-027 Reset mid-set or mid-WAIT SHALL discard partial beats and the pending done without an err pulse; a done arriving after reset SHALL be ignored.

Configuration
REQ-028 The macro FSMD_LOADER_CHECKSUM_EN SHALL compile in checksum support.
REQ-029 With the macro defined, the 5th accepted beat SHALL enter CHK; in CHK, one further beat (the 6th) SHALL be accepted and compared with the XOR of the five operand beats.
REQ-030 On a checksum match, the block SHALL enter ISSUE, with a..e loaded at that edge.
REQ-031 On a checksum mismatch, the block SHALL pulse err for one cycle, discard the set, return to LOAD with idx=0, and leave a..e unchanged.
REQ-032 With the macro undefined, there SHALL be no CHK state and no checksum logic, and the behaviour SHALL be as in REQ-017.

Structure
REQ-033 Package fsmd_pkg SHALL hold the state enum type, the constant N_OPERANDS=5 and the default DATA_W.
REQ-034 The done/timeout counter SHALL be the sub-module fsmd_done_timer, with inputs clock, reset, clear and enable and output expired.

Verification
REQ-035 The bench SHALL cover: beats 1,2,3,4,5 with in_valid held high → a..e=1..5 and start high exactly one cycle after the 5th beat; done two cycles later → in_ready=1 on the next cycle.
REQ-036 The bench SHALL cover: in_valid toggled each cycle during load → five beats captured in order, with no loss or duplication.
REQ-037 The bench SHALL cover: no done after start → err pulse exactly DONE_TIMEOUT cycles into WAIT, then LOAD with busy=0.
REQ-038 The bench SHALL cover: done asserted on the timeout cycle → no err, return to LOAD.
REQ-039 The bench SHALL cover: reset asserted after 3 beats → all outputs 0; the next five beats form a new set, 6,7,8,9,10 → a..e=6..10.
REQ-040 The bench SHALL cover, with FSMD_LOADER_CHECKSUM_EN defined: beats 1,2,3,4,5 then checksum 1 → start; beats 1,2,3,4,5 then checksum 0 → err, no start, a..e unchanged.
